// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and default widths for the memory-access stage.
// Consumed by mem_access_unit, its interface and the lane-alignment helper.
package mem_access_unit_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    MOP_NONE  = 2'b00,
    MOP_LOAD  = 2'b01,
    MOP_STORE = 2'b10,
    MOP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mau_state_e;

  // Half needs addr[0]=0; word (and the reserved size, handled as word) needs addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF) begin
      bad = addr_lo[0];
    end else if (size != SZ_BYTE) begin
      bad = (addr_lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of execute-side, data-memory and write-back signals of the memory-access stage.
// slave: the stage itself; master: its environment (execute, memory, write-back).
interface mem_access_unit_if #(
  parameter int XLEN   = mem_access_unit_pkg::DEF_XLEN,
  parameter int REG_AW = mem_access_unit_pkg::DEF_REG_AW
);

  logic              ex_valid;
  logic              ex_ready;
  logic [1:0]        ex_mem_op;
  logic [1:0]        ex_size;
  logic              ex_unsigned;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   ex_store_data;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write_en;

  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [3:0]        dmem_be;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;

  logic              wb_valid;
  logic              reg_write_en;
  logic [XLEN-1:0]   exe_result;
  logic [REG_AW-1:0] rd_addr;
  logic              from_mem;
  logic [REG_AW-1:0] store_data_to;
  logic [XLEN-1:0]   read_data;
  logic              misalign_err;

  modport slave (
    input  ex_valid, ex_mem_op, ex_size, ex_unsigned, ex_result, ex_store_data,
           ex_rd_addr, ex_reg_write_en, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, reg_write_en, exe_result, rd_addr, from_mem, store_data_to,
           read_data, misalign_err
  );

  modport master (
    output ex_valid, ex_mem_op, ex_size, ex_unsigned, ex_result, ex_store_data,
           ex_rd_addr, ex_reg_write_en, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, reg_write_en, exe_result, rd_addr, from_mem, store_data_to,
           read_data, misalign_err
  );

endinterface

// File: rtl/mem_access_unit_mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for the
// request, and lane extraction with sign/zero extension for returned load words.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel    = lane[addr_lo_i];
    half_sel    = {lane[{addr_lo_i[1], 1'b1}], lane[{addr_lo_i[1], 1'b0}]};
    be_o        = 4'hF;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {(XLEN/8){store_data_i[7:0]}};
        load_data_o = {{(XLEN-8){byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
      SZ_HALF: begin
        // addr[0] is deliberately ignored: a half always sits in lane pair 0/1 or 2/3
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o     = {(XLEN/16){store_data_i[15:0]}};
        load_data_o = {{(XLEN-16){half_sel[15] & ~unsigned_i}}, half_sel};
      end
      default: begin
        be_o        = 4'hF;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: one instruction at a time, optional load/store over a
// req/ack port, registered write-back bundle. MEM_ALIGN_CHECK_EN enables misalignment trapping.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  mau_state_e        state_q, state_d;

  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_we_q, rd_we_d;

  logic              wb_valid_q, wb_valid_d;
  logic              reg_write_en_q, reg_write_en_d;
  logic [XLEN-1:0]   exe_result_q, exe_result_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              from_mem_q, from_mem_d;
  logic [REG_AW-1:0] store_data_to_q, store_data_to_d;
  logic [XLEN-1:0]   read_data_q, read_data_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  logic [3:0]        lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_load;
  logic              access_active;

  mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (bus.dmem_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  always_comb begin
    state_d         = state_q;
    is_store_d      = is_store_q;
    size_d          = size_q;
    uns_d           = uns_q;
    addr_d          = addr_q;
    sdata_d         = sdata_q;
    rd_d            = rd_q;
    rd_we_d         = rd_we_q;
    wb_valid_d      = 1'b0;
    reg_write_en_d  = reg_write_en_q;
    exe_result_d    = exe_result_q;
    rd_addr_d       = rd_addr_q;
    from_mem_d      = from_mem_q;
    store_data_to_d = store_data_to_q;
    read_data_d     = read_data_q;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid) begin
          is_store_d = (bus.ex_mem_op == MOP_STORE);
          size_d     = bus.ex_size;
          uns_d      = bus.ex_unsigned;
          addr_d     = bus.ex_result;
          sdata_d    = bus.ex_store_data;
          rd_d       = bus.ex_rd_addr;
          rd_we_d    = bus.ex_reg_write_en;
          if (bus.ex_mem_op == MOP_LOAD || bus.ex_mem_op == MOP_STORE) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (is_misaligned(bus.ex_size, bus.ex_result[1:0])) begin
              wb_valid_d     = 1'b1;
              misalign_d     = 1'b1;
              reg_write_en_d = 1'b0;
              from_mem_d     = 1'b0;
            end else begin
              state_d = ST_ACCESS;
            end
`else
            state_d = ST_ACCESS;
`endif
          end else begin
            // Reserved op code behaves exactly like "none": plain ALU write-back
            wb_valid_d     = 1'b1;
            reg_write_en_d = bus.ex_reg_write_en;
            exe_result_d   = bus.ex_result;
            rd_addr_d      = bus.ex_rd_addr;
            from_mem_d     = 1'b0;
          end
        end
      end

      ST_ACCESS: begin
        if (bus.dmem_ack) begin
          state_d        = ST_IDLE;
          wb_valid_d     = 1'b1;
          reg_write_en_d = 1'b0;
          if (is_store_q) begin
            from_mem_d = 1'b0;
          end else begin
            from_mem_d      = rd_we_q;
            store_data_to_d = rd_q;
            read_data_d     = lane_load;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      is_store_q      <= 1'b0;
      size_q          <= 2'b00;
      uns_q           <= 1'b0;
      addr_q          <= '0;
      sdata_q         <= '0;
      rd_q            <= '0;
      rd_we_q         <= 1'b0;
      wb_valid_q      <= 1'b0;
      reg_write_en_q  <= 1'b0;
      exe_result_q    <= '0;
      rd_addr_q       <= '0;
      from_mem_q      <= 1'b0;
      store_data_to_q <= '0;
      read_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      addr_q          <= addr_d;
      sdata_q         <= sdata_d;
      rd_q            <= rd_d;
      rd_we_q         <= rd_we_d;
      wb_valid_q      <= wb_valid_d;
      reg_write_en_q  <= reg_write_en_d;
      exe_result_q    <= exe_result_d;
      rd_addr_q       <= rd_addr_d;
      from_mem_q      <= from_mem_d;
      store_data_to_q <= store_data_to_d;
      read_data_q     <= read_data_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  // Request fields are decoded straight from state so reset drops dmem_req without a clock
  assign access_active   = (state_q == ST_ACCESS);
  assign bus.ex_ready    = (state_q == ST_IDLE);
  assign bus.dmem_req    = access_active;
  assign bus.dmem_we     = access_active & is_store_q;
  assign bus.dmem_addr   = access_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.dmem_be     = access_active ? lane_be : 4'h0;
  assign bus.dmem_wdata  = access_active ? lane_wdata : '0;

  assign bus.wb_valid      = wb_valid_q;
  assign bus.reg_write_en  = reg_write_en_q;
  assign bus.exe_result    = exe_result_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.from_mem      = from_mem_q;
  assign bus.store_data_to = store_data_to_q;
  assign bus.read_data     = read_data_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the pipeline: accepts one instruction at a time from execute, performs an optional load or store on the data-memory port with a req/ack handshake, and presents a registered result bundle to `WB_Unit`. Loads produce `from_mem`/`store_data_to`/`read_data`; ALU results pass through as `reg_write_en`/`exe_result`/`rd_addr`. Byte/half/word accesses are little-endian with lane steering and sign/zero extension.

## Interface
- `XLEN`, 32, data/address width
- `REG_AW`, 5, register-address width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `ex_valid` in 1: execute offers an instruction
- `ex_ready` out 1: stage can accept (high only in IDLE)
- `ex_mem_op` in 2: 00 none, 01 load, 10 store, 11 reserved (treated as none)
- `ex_size` in 2: 00 byte, 01 half, 10 word
- `ex_unsigned` in 1: zero-extend loads
- `ex_result` in XLEN: ALU result; memory address for loads/stores
- `ex_store_data` in XLEN: store source
- `ex_rd_addr` in REG_AW: destination register
- `ex_reg_write_en` in 1: instruction writes rd
- `dmem_req` out 1: access request, held until ack
- `dmem_we` out 1: 1 store, 0 load
- `dmem_addr` out XLEN: word-aligned (`[1:0]`=0)
- `dmem_be` out 4: byte enables
- `dmem_wdata` out XLEN: lane-replicated store data
- `dmem_ack` in 1: access complete; `dmem_rdata` valid same cycle
- `dmem_rdata` in XLEN: load word
- `wb_valid` out 1: one-cycle pulse, bundle below valid
- `reg_write_en`, `exe_result`, `rd_addr` out 1/XLEN/REG_AW: ALU write-back to `WB_Unit`
- `from_mem`, `store_data_to`, `read_data` out 1/REG_AW/XLEN: load write-back to `WB_Unit`
- `misalign_err` out 1: one-cycle pulse (only with macro)

## Operation
- FSM states IDLE, ACCESS. Reset -> IDLE; all outputs 0, `ex_ready`=1 after reset deasserts.
- IDLE, `ex_valid`=1: capture all `ex_*` fields. mem_op none/reserved -> stay IDLE, next cycle `wb_valid`=1, `reg_write_en`=`ex_reg_write_en`, `from_mem`=0. Load/store -> ACCESS.
- ACCESS: `dmem_req`=1, address/be/wdata/we stable until `dmem_ack`. On ack: load captures extracted `dmem_rdata`; next cycle `wb_valid`=1, return to IDLE.
- Load: `from_mem`=1 only if captured `ex_reg_write_en`; `store_data_to`=rd; `reg_write_en`=0. `from_mem` and `reg_write_en` never both 1.
- Store: `wb_valid`=1 with `reg_write_en`=`from_mem`=0.
- Byte: be=`4'b0001<<addr[1:0]`, wdata=byte replicated ×4, rdata lane `addr[1:0]`. Half: be=`4'b0011<<{addr[1],1'b0}`, lane `addr[1]`. Word: be=`4'hF`.
- Extension: sign bit of selected lane unless `ex_unsigned`; word ignores `ex_unsigned`.
- Outputs other than `wb_valid`/`misalign_err` hold last value between pulses.

## Timing
- Non-memory latency: accept edge N -> `wb_valid` during cycle N+1; `ex_ready` stays 1, back-to-back accepts every cycle.
- Memory latency: `dmem_req` rises cycle N+1; ack in cycle N+1+k (k≥0) -> `wb_valid` cycle N+2+k; `ex_ready`=0 from N+1 until ack cycle inclusive.
- Ack while `dmem_req`=0: ignored.
- `rst` mid-ACCESS: immediate return to IDLE, `dmem_req` drops asynchronously, captured instruction discarded, no `wb_valid`.
- No timeout; memory must eventually ack.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: half with `addr[0]`=1 or word with `addr[1:0]`≠0 never raises `dmem_req`; next cycle `wb_valid`=1, `misalign_err`=1, `reg_write_en`=`from_mem`=0, stay IDLE.
- Undefined: low address bits ignored for half (`addr[0]`) and word (`addr[1:0]`), access proceeds; `misalign_err` tied 0.

## Structure
- Shared package: mem_op and size encodings, FSM state encoding, `XLEN`/`REG_AW` defaults.
- One sub-module `mem_lane_align`: combinational be/wdata generation and load extraction/extension.

## Test plan
- ALU op: `ex_result`=0x12345678, rd=10, we=1, mem_op none -> next cycle `wb_valid`, `reg_write_en`=1, `rd_addr`=10, `exe_result`=0x12345678, `from_mem`=0.
- Word load addr 0x100, rd=12, ack after 3 cycles with 0xCAFEBABE -> `dmem_req` 3 cycles, `dmem_be`=F, then `from_mem`=1, `store_data_to`=12, `read_data`=0xCAFEBABE.
- Byte loads addr 0x103, rdata 0x80FFFFFF: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0xABCD at 0x202 -> `dmem_addr`=0x200, be=1100, wdata=0xABCDABCD, `dmem_we`=1; `wb_valid` with no register write.
- `rst` asserted during ACCESS wait -> `dmem_req` 0 immediately, no `wb_valid`; later load completes normally.
- Word load at 0x101: with `MEM_ALIGN_CHECK_EN` -> no `dmem_req`, `misalign_err`+`wb_valid` next cycle; without -> `dmem_addr`=0x100, normal load.
